dds_freq_detect: RTL and testbench
==================================

Name: dds_freq_detect

Overview:
Receive-side companion of the cosine DDS. Watches the DDS half-cycle flag (`sym`) and measures the clock count between successive `sym` toggles. It divides that count by the fixed per-toggle step count to recover the 4-bit divider word that drove the generator. It reports the word with a one-cycle valid strobe, plus lock and error status, to the control logic that checks or echoes the programmed frequency.

Parameters:
- STEPS, 506, DDS table steps between two sym toggles (253 down plus 253 up).
- TOL, 0, accepted remainder deviation in clocks (0 = exact match required).
- CNT_W, 14, period counter width; must hold STEPS*17.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- sym_in  input  1  DDS sym flag, asynchronous to the clk edge used here.
- data_out  output  4  recovered divider word.
- valid  output  1  one-cycle strobe; data_out is updated in the same cycle.
- locked  output  1  high while the last two accepted words were equal.
- err  output  1  one-cycle strobe on a bad period or timeout.

Behaviour:
- Reset (sync, rst=1 at a clk edge): data_out=0, valid=0, locked=0, err=0, state=IDLE, counters=0, sync flops=0.
- Input path:
  - sym_in passes through a 2-flop synchronizer.
  - An edge is any change between sync stage 2 and a third delay flop, either polarity.
  - Edge-detect latency is 3 clk from a sym_in change.
- Period counter (CNT_W bits):
  - Loads 1 on the cycle after an edge.
  - Otherwise increments by 1 while state is not IDLE.
  - It keeps running during DIVIDE, so measurement is continuous. DIVIDE takes at most 19 cycles, well under the minimum period of STEPS.
- States:
  - IDLE: wait for the first edge, then go to MEASURE and load counter=1. No result is produced from the first edge.
  - MEASURE: on an edge, latch period=counter into rem, set q=0, go to DIVIDE.
    - If counter reaches STEPS*17 with no edge: err=1 for one cycle, locked=0, go to IDLE.
  - DIVIDE: one subtraction per cycle.
    - If rem>=STEPS and q<17: rem-=STEPS, q+=1.
    - Otherwise go to REPORT.
  - REPORT (one cycle):
    - If rem>=STEPS-TOL (with TOL>0), set qf=q+1; else qf=q.
    - Accept iff (rem<=TOL or rem>=STEPS-TOL) and 1<=qf<=16.
    - Accept: data_out=qf-1, valid=1. locked=1 if qf-1 equals the previous accepted word and a previous word exists since lock loss; otherwise locked=0.
    - Reject: err=1, locked=0, data_out holds.
    - Always return to MEASURE.
- Edge during DIVIDE or REPORT: the period counter still reloads to 1. The edge is not otherwise lost, because the counter restarted on it. Two edges inside one DIVIDE is impossible for legal input and need not be handled.
- valid and err are never high in the same cycle. Each is high for exactly 1 cycle per event.
- Result latency from the edge-detect cycle: 1 (latch) + q (divide steps) + 1 (REPORT).
- Counter saturation cannot occur because the timeout fires first.
- rst mid-DIVIDE aborts with no valid or err. The first result after reset requires two edges.

Decomposition:
- Shared package `dds_pkg`: DDS_STEPS=506, DDS_WORD_W=4, DDS_MAX_DIV=16, and the state encoding `fd_state_t` (IDLE, MEASURE, DIVIDE, REPORT). The DDS generator takes its table length from the same constants.
- One natural sub-module: `edge_sync`, holding the 2-flop synchronizer plus the delay flop and the any-edge pulse output. Everything else stays in the top module.

Test Plan:
- Drive a DDS model with data=3 (toggle every 2024 clk) -> first valid=1 with data_out=3 after the 2nd edge, locked=0; second valid gives locked=1; err never asserts.
- data=0 (period 506) and data=15 (period 8096) -> data_out=0 and data_out=15 respectively, locked after two results, no err.
- Switch the DDS from data=3 to data=7 mid-stream -> one valid with data_out=7 and locked=0, then locked=1 on the next result.
- Toggle sym every 1000 clk with TOL=0 -> err pulses each period, valid never asserts, locked=0.
- Toggle sym every 500 clk (qf=0) -> err pulses, valid never asserts.
- Hold sym constant after lock -> err at counter=8602 (STEPS*17), locked=0, state IDLE; a resumed data=5 stream produces its first valid with data_out=5 after two edges.
- Assert rst one cycle during DIVIDE -> no valid or err, all outputs 0, and the next result needs two fresh edges.

Source files
------------

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared DDS constants and frequency-detector state encoding
package dds_pkg;

    // Table steps between two sym toggles (253 down plus 253 up)
    localparam int DDS_STEPS   = 506;
    localparam int DDS_WORD_W  = 4;
    localparam int DDS_MAX_DIV = 16;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE,
        REPORT
    } fd_state_t;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with any-polarity edge pulse
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sym_i,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Two metastability stages followed by one delay stage used for edge compare
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sym_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/dds_freq_detect.sv
// rtl/dds_freq_detect.sv - recovers the DDS divider word from the sym toggle period
module dds_freq_detect
    import dds_pkg::*;
#(
    parameter int STEPS = DDS_STEPS,
    parameter int TOL   = 0,
    parameter int CNT_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sym_in,
    output logic [DDS_WORD_W-1:0] data_out,
    output logic                  valid,
    output logic                  locked,
    output logic                  err
);

    localparam logic [CNT_W-1:0] STEPS_C   = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] HI_C      = CNT_W'(STEPS - TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(STEPS * (DDS_MAX_DIV + 1));
    localparam logic [4:0]       Q_LIM     = 5'(DDS_MAX_DIV + 1);

    fd_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [4:0]            q_q, q_d;
    logic [DDS_WORD_W-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  locked_q, locked_d;
    logic                  have_prev_q, have_prev_d;

    logic                  sym_edge;
    logic [4:0]            qf;
    logic                  accept;
    logic [DDS_WORD_W-1:0] word;

    edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .sym_i  (sym_in),
        .edge_o (sym_edge)
    );

    // Round up when the remainder sits just below a full step (only with TOL>0)
    assign qf     = ((TOL > 0) && (rem_q >= HI_C)) ? q_q + 5'd1 : q_q;
    assign accept = ((rem_q <= TOL_C) || (rem_q >= HI_C))
                    && (qf >= 5'd1) && (qf <= 5'(DDS_MAX_DIV));
    assign word   = DDS_WORD_W'(qf - 5'd1);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
            have_prev_q <= have_prev_d;
        end
    end

    // Next state: continuous period counter, restoring division, result reporting
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        q_d         = q_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        locked_d    = locked_q;
        have_prev_d = have_prev_q;

        // The counter restarts on every edge, even mid-divide, so no period is lost
        if (sym_edge) begin
            cnt_d = CNT_W'(1);
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sym_edge) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (sym_edge) begin
                    rem_d   = cnt_q;
                    q_d     = '0;
                    state_d = DIVIDE;
                end else if (cnt_q >= TIMEOUT_C) begin
                    err_d       = 1'b1;
                    locked_d    = 1'b0;
                    have_prev_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            DIVIDE: begin
                if ((rem_q >= STEPS_C) && (q_q < Q_LIM)) begin
                    rem_d = rem_q - STEPS_C;
                    q_d   = q_q + 5'd1;
                    // Look ahead so the last subtraction goes straight to REPORT
                    if (!((rem_d >= STEPS_C) && (q_d < Q_LIM))) begin
                        state_d = REPORT;
                    end
                end else begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (accept) begin
                    data_d      = word;
                    valid_d     = 1'b1;
                    locked_d    = have_prev_q && (word == data_q);
                    have_prev_d = 1'b1;
                end else begin
                    err_d       = 1'b1;
                    locked_d    = 1'b0;
                    have_prev_d = 1'b0;
                end
                state_d = MEASURE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_dds_freq_detect.sv
// tb/tb_dds_freq_detect.sv - self-checking bench for dds_freq_detect
module tb_dds_freq_detect;

    localparam int TIMEOUT = 506 * 17;

    logic       clk = 1'b0;
    logic       rst;
    logic       sym_in;
    logic [3:0] data_out;
    logic       valid;
    logic       locked;
    logic       err;

    dds_freq_detect dut (
        .clk      (clk),
        .rst      (rst),
        .sym_in   (sym_in),
        .data_out (data_out),
        .valid    (valid),
        .locked   (locked),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         period;
        int         toggles;
        int         hold_before;
        bit         ok;
        logic [3:0] word;
    } seg_t;

    typedef struct {
        bit         is_valid;
        logic [3:0] data;
        bit         lk;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    seg_t       tbl[9];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    bit         armed = 1'b0;
    bit         have_prev = 1'b0;
    logic [3:0] last_word = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected outcome of one measured period, with the lock history kept here
    task automatic push_result(input bit ok, input logic [3:0] w);
        exp_t x;
        if (ok) begin
            x.is_valid = 1'b1;
            x.data     = w;
            x.lk       = have_prev && (w == last_word);
            have_prev  = 1'b1;
            last_word  = w;
        end else begin
            x.is_valid = 1'b0;
            x.data     = last_word;
            x.lk       = 1'b0;
            have_prev  = 1'b0;
        end
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (armed && (cyc - last_cyc >= TIMEOUT)) begin
            push_result(1'b0, 4'd0);
            armed = 1'b0;
        end
    endtask

    task automatic toggle(input bit ok, input logic [3:0] w);
        sym_in = ~sym_in;
        if (armed) push_result(ok, w);
        else armed = 1'b1;
        last_cyc = cyc;
    endtask

    task automatic run_seg(input seg_t s);
        repeat (s.hold_before) tick();
        for (int t = 0; t < s.toggles; t++) begin
            repeat (s.period) tick();
            toggle(s.ok, s.word);
        end
    endtask

    // Every valid/err pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (valid || err)) begin
            check("valid_err_exclusive", 32'(valid && err), 0);
            if (sb.size() == 0) begin
                check("unexpected_event", 32'(valid), 32'(err));
                check("unexpected_event_any", 1, 0);
            end else begin
                e = sb.pop_front();
                check("event_kind_valid", 32'(valid), 32'(e.is_valid));
                check("data_out", 32'(data_out), 32'(e.data));
                check("locked", 32'(locked), 32'(e.lk));
            end
        end
    end

    initial begin
        seg_t extra;

        tbl[0] = '{period: 2024, toggles: 3, hold_before: 0,    ok: 1'b1, word: 4'd3};
        tbl[1] = '{period: 506,  toggles: 2, hold_before: 0,    ok: 1'b1, word: 4'd0};
        tbl[2] = '{period: 8096, toggles: 2, hold_before: 0,    ok: 1'b1, word: 4'd15};
        tbl[3] = '{period: 2024, toggles: 2, hold_before: 0,    ok: 1'b1, word: 4'd3};
        tbl[4] = '{period: 4048, toggles: 2, hold_before: 0,    ok: 1'b1, word: 4'd7};
        tbl[5] = '{period: 1000, toggles: 2, hold_before: 0,    ok: 1'b0, word: 4'd0};
        tbl[6] = '{period: 500,  toggles: 2, hold_before: 0,    ok: 1'b0, word: 4'd0};
        tbl[7] = '{period: 2024, toggles: 2, hold_before: 0,    ok: 1'b1, word: 4'd3};
        tbl[8] = '{period: 3036, toggles: 3, hold_before: 8700, ok: 1'b1, word: 4'd5};

        rst    = 1'b1;
        sym_in = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_data_out", 32'(data_out), 0);
        check("reset_valid", 32'(valid), 0);
        check("reset_locked", 32'(locked), 0);
        check("reset_err", 32'(err), 0);

        for (int i = 0; i < 9; i++) run_seg(tbl[i]);

        // Reset mid-divide: the toggle must leave sym low so reset sees no edge
        extra = '{period: 2024, toggles: 1, hold_before: 0, ok: 1'b1, word: 4'd3};
        if (sym_in == 1'b0) run_seg(extra);
        run_seg(extra);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        armed     = 1'b0;
        have_prev = 1'b0;
        last_word = 4'd0;
        check("midreset_data_out", 32'(data_out), 0);
        check("midreset_valid", 32'(valid), 0);
        check("midreset_locked", 32'(locked), 0);
        check("midreset_err", 32'(err), 0);

        extra = '{period: 2024, toggles: 3, hold_before: 0, ok: 1'b1, word: 4'd3};
        run_seg(extra);

        repeat (40) tick();
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
